// File: rtl/sw_operand_debounce.sv
// ---------------------------------------------------------------------------
// sw_operand_debounce
//   Input stage of the adder/subtractor demo. Synchronises the nine raw board
//   switches (SW15..SW8, SW0) into the CLK domain and debounces each bit
//   independently. A bit's debounced value follows the switch only after the
//   switch has disagreed with it on STABLE_SAMPLES consecutive sample ticks.
//   One sample tick is generated every INTERVAL clock cycles.
//
// Parameters
//   INTERVAL        sample-tick period in CLK cycles (>= 1)
//   STABLE_SAMPLES  consecutive mismatching ticks needed to update (>= 1)
//
// Ports
//   CLK             system clock, rising edge
//   RST             asynchronous active-high reset
//   SW_IN[8:0]      raw switches: [8:5]=SW15..SW12, [4:1]=SW11..SW8, [0]=SW0
//   a[3:0]          debounced SW15..SW12
//   b[3:0]          debounced SW11..SW8
//   add_sub_signal  debounced SW0 (0 = add, 1 = subtract)
//   upd             one-cycle pulse in the first cycle new values are visible
// ---------------------------------------------------------------------------
module sw_operand_debounce #(
  parameter int unsigned INTERVAL       = 100000 / 2,
  parameter int unsigned STABLE_SAMPLES = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [8:0] SW_IN,
  output logic [3:0] a,
  output logic [3:0] b,
  output logic       add_sub_signal,
  output logic       upd
);

  localparam int unsigned NBITS  = 9;
  localparam int unsigned TCNT_W = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
  localparam int unsigned SCNT_W = $clog2(STABLE_SAMPLES + 1);

  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(INTERVAL - 1);
  localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(STABLE_SAMPLES - 1);

  // Two-flop synchroniser per switch bit
  logic [NBITS-1:0] sync1_q;
  logic [NBITS-1:0] sync2_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= SW_IN;
      sync2_q <= sync1_q;
    end
  end

  // Free-running sample-tick counter; its period ignores switch activity
  logic [TCNT_W-1:0] tcnt_q;
  logic [TCNT_W-1:0] tcnt_d;
  logic              tick_c;

  assign tick_c = (tcnt_q == TCNT_LAST);

  always_comb begin
    tcnt_d = tcnt_q + TCNT_W'(1);
    if (tick_c) begin
      tcnt_d = '0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tcnt_q <= '0;
    end else begin
      tcnt_q <= tcnt_d;
    end
  end

  // Per-bit debounce state: debounced level and mismatch-tick counter
  logic [NBITS-1:0]             db_q;
  logic [NBITS-1:0]             db_d;
  logic [NBITS-1:0][SCNT_W-1:0] scnt_q;
  logic [NBITS-1:0][SCNT_W-1:0] scnt_d;
  logic [NBITS-1:0]             chg_c;
  logic                         upd_q;
  logic                         upd_d;

  // Per-bit update rule, evaluated only on sample ticks. A tick on which the
  // synchronised input agrees with the debounced level restarts the count,
  // so a bounce caught by any tick cancels progress toward an update.
  always_comb begin
    db_d   = db_q;
    scnt_d = scnt_q;
    chg_c  = '0;
    if (tick_c) begin
      for (int unsigned i = 0; i < NBITS; i++) begin
        if (sync2_q[i] == db_q[i]) begin
          scnt_d[i] = '0;
        end else if (scnt_q[i] == SCNT_LAST) begin
          db_d[i]   = sync2_q[i];
          scnt_d[i] = '0;
          chg_c[i]  = 1'b1;
        end else begin
          scnt_d[i] = scnt_q[i] + SCNT_W'(1);
        end
      end
    end
  end

  // Several bits flipping on one tick collapse into a single pulse
  assign upd_d = |chg_c;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      db_q   <= '0;
      scnt_q <= '0;
      upd_q  <= 1'b0;
    end else begin
      db_q   <= db_d;
      scnt_q <= scnt_d;
      upd_q  <= upd_d;
    end
  end

  // Outputs come straight from registers; upd lands with the new data
  assign a              = db_q[8:5];
  assign b              = db_q[4:1];
  assign add_sub_signal = db_q[0];
  assign upd            = upd_q;

endmodule

// File: tb/tb_sw_operand_debounce.sv
module tb_sw_operand_debounce;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // dut0: INTERVAL=4, STABLE_SAMPLES=3; dut1: INTERVAL=1, STABLE_SAMPLES=3
  logic       rst0, rst1;
  logic [8:0] sw0, sw1;
  logic [3:0] a0, b0, a1, b1;
  logic       as0, as1, upd0, upd1;

  sw_operand_debounce #(.INTERVAL(4), .STABLE_SAMPLES(3)) u_dut0 (
    .CLK(clk), .RST(rst0), .SW_IN(sw0),
    .a(a0), .b(b0), .add_sub_signal(as0), .upd(upd0)
  );

  sw_operand_debounce #(.INTERVAL(1), .STABLE_SAMPLES(3)) u_dut1 (
    .CLK(clk), .RST(rst1), .SW_IN(sw1),
    .a(a1), .b(b1), .add_sub_signal(as1), .upd(upd1)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [8:0] val;
    int         lo;
    int         hi;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Drive point: 2 time units after a rising edge
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Monitor dut0: every upd pops one expectation; without upd nothing may move
  exp_t       e0;
  logic [8:0] prev0 = '0;
  always @(negedge clk) begin
    if (rst0) begin
      prev0 = '0;
    end else begin
      if (upd0) begin
        if (q0.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL dut0_unexpected_upd actual=%0h required=no_pulse (cycle %0d)",
                   {a0, b0, as0}, cyc);
        end else begin
          e0 = q0.pop_front();
          chk("dut0_value", 32'({a0, b0, as0}), 32'(e0.val));
          checks++;
          if (cyc < e0.lo || cyc > e0.hi) begin
            errors++;
            $display("FAIL dut0_latency actual=cycle %0d required=cycle %0d..%0d",
                     cyc, e0.lo, e0.hi);
          end
        end
      end else begin
        chk("dut0_steady", 32'({a0, b0, as0}), 32'(prev0));
      end
      prev0 = {a0, b0, as0};
    end
  end

  // Monitor dut1
  exp_t       e1;
  logic [8:0] prev1 = '0;
  always @(negedge clk) begin
    if (rst1) begin
      prev1 = '0;
    end else begin
      if (upd1) begin
        if (q1.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL dut1_unexpected_upd actual=%0h required=no_pulse (cycle %0d)",
                   {a1, b1, as1}, cyc);
        end else begin
          e1 = q1.pop_front();
          chk("dut1_value", 32'({a1, b1, as1}), 32'(e1.val));
          checks++;
          if (cyc < e1.lo || cyc > e1.hi) begin
            errors++;
            $display("FAIL dut1_latency actual=cycle %0d required=cycle %0d..%0d",
                     cyc, e1.lo, e1.hi);
          end
        end
      end else begin
        chk("dut1_steady", 32'({a1, b1, as1}), 32'(prev1));
      end
      prev1 = {a1, b1, as1};
    end
  end

  task automatic push0(input logic [8:0] v, input int lo, input int hi);
    exp_t e;
    e.val = v;
    e.lo  = cyc + lo;
    e.hi  = cyc + hi;
    q0.push_back(e);
  endtask

  task automatic push1(input logic [8:0] v, input int lo, input int hi);
    exp_t e;
    e.val = v;
    e.lo  = cyc + lo;
    e.hi  = cyc + hi;
    q1.push_back(e);
  endtask

  initial begin
    rst0 = 1'b1;
    rst1 = 1'b1;
    sw0  = '0;
    sw1  = '0;
    #3;
    chk("reset_a", 32'(a0), 32'h0);
    chk("reset_b", 32'(b0), 32'h0);
    chk("reset_as", 32'(as0), 32'h0);
    chk("reset_upd", 32'(upd0), 32'h0);
    chk("reset1_all", 32'({a1, b1, as1, upd1}), 32'h0);
    wait_cyc(3);
    rst0 = 1'b0;
    rst1 = 1'b0;

    // Exact latency with a tick every cycle: 2 sync + 3 samples
    wait_cyc(5);
    sw1 = 9'h001;
    push1(9'h001, 5, 5);
    wait_cyc(12);
    sw1 = 9'h000;
    push1(9'h000, 5, 5);
    wait_cyc(12);

    // Idle with switches low: no pulse expected
    wait_cyc(100);

    // Clean step
    sw0 = 9'h1A5;
    push0(9'h1A5, 11, 14);
    wait_cyc(20);
    chk("step_a", 32'(a0), 32'hD);
    chk("step_b", 32'(b0), 32'h2);
    chk("step_as", 32'(as0), 32'h1);

    // Asynchronous reset mid-cycle clears outputs before the next edge
    rst0 = 1'b1;
    sw0  = 9'h000;
    #1;
    chk("async_rst_a", 32'(a0), 32'h0);
    chk("async_rst_b", 32'(b0), 32'h0);
    chk("async_rst_as", 32'(as0), 32'h0);
    chk("async_rst_upd", 32'(upd0), 32'h0);
    wait_cyc(2);
    rst0 = 1'b0;
    wait_cyc(100);

    // Bounce: 6-cycle levels never span three ticks
    for (int k = 0; k < 34; k++) begin
      sw0[0] = ~sw0[0];
      wait_cyc(6);
    end
    chk("bounce_as", 32'(as0), 32'h0);
    sw0[0] = 1'b1;
    push0(9'h001, 11, 14);
    wait_cyc(20);

    // Reset in the middle of a count
    sw0 = 9'h1FE;
    wait_cyc(8);
    rst0 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_cyc(1);
      chk("midrst_outputs", 32'({a0, b0, as0, upd0}), 32'h0);
    end
    rst0 = 1'b0;
    push0(9'h1FE, 11, 14);
    wait_cyc(20);
    chk("midrst_a", 32'(a0), 32'hF);
    chk("midrst_b", 32'(b0), 32'hF);

    // Staggered bits: separate pulses
    sw0[8] = 1'b0;
    push0(9'h0FE, 11, 14);
    wait_cyc(20);
    sw0[1] = 1'b0;
    push0(9'h0FC, 11, 14);
    wait_cyc(20);
    chk("stagger_a", 32'(a0), 32'h7);
    chk("stagger_b", 32'(b0), 32'hE);

    chk("dut0_pending", 32'(q0.size()), 32'h0);
    chk("dut1_pending", 32'(q1.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
